bsg_wormhole_concentrator_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter that merges num_in_p wormhole flit streams onto one wormhole link.
- Sits between several concentrator test nodes (or client PISO outputs) and a shared router port.
- Once a header flit wins arbitration, the output is locked to that input until the whole packet has passed.
- Zero-latency, bufferless: flits pass combinationally from the selected input to the output.

---
 rtl/bsg_wormhole_concentrator_arbiter.sv | 132 +++++++++++++
 tb/tb_bsg_wormhole_concentrator_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_concentrator_arbiter.sv
// Packet-atomic round-robin arbiter merging num_in_p wormhole flit streams onto one link.
// Bufferless: the selected input's valid/data/ready pass combinationally; a header with len != 0 locks the output.
module bsg_wormhole_concentrator_arbiter #(
    parameter int num_in_p     = 4,
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 3,
    localparam int lg_num_in_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p-1:0]              v_i,
    input  logic [num_in_p*flit_width_p-1:0] data_i,
    output logic [num_in_p-1:0]              ready_and_o,
    output logic                             v_o,
    output logic [flit_width_p-1:0]          data_o,
    input  logic                             ready_and_i,
    output logic [lg_num_in_lp-1:0]          grant_o,
    output logic                             locked_o
);

    // Handshake: a flit moves on input k when v_i[k] & ready_and_o[k]; on the output when v_o & ready_and_i.
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                  state_r, state_n;
    logic [lg_num_in_lp-1:0] rr_ptr_r, rr_ptr_n;
    logic [lg_num_in_lp-1:0] owner_r, owner_n;
    logic [len_width_p-1:0]  remain_r, remain_n;

    logic [lg_num_in_lp-1:0] sel;
    logic                    found;
    logic [lg_num_in_lp-1:0] cur;
    logic                    hs;
    logic [len_width_p-1:0]  hdr_len;

    function automatic logic [lg_num_in_lp-1:0] wrap_idx(input logic [lg_num_in_lp-1:0] base,
                                                         input int off);
        int s;
        s = (int'(base) + off) % num_in_p;
        return lg_num_in_lp'(s);
    endfunction

    // Round-robin search starting at rr_ptr_r; defaults to input 0 when nobody requests.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < num_in_p; i++) begin
            if (!found && v_i[wrap_idx(rr_ptr_r, i)]) begin
                found = 1'b1;
                sel   = wrap_idx(rr_ptr_r, i);
            end
        end
    end

    assign cur = (state_r == LOCKED) ? owner_r : sel;

    // Outputs are forced quiet while reset is held so the async reset takes effect at once.
    always_comb begin
        v_o         = 1'b0;
        ready_and_o = '0;
        grant_o     = '0;
        data_o      = data_i[flit_width_p-1:0];
        if (!reset_i) begin
            grant_o = cur;
            v_o     = v_i[cur];
            for (int k = 0; k < num_in_p; k++) begin
                if (cur == lg_num_in_lp'(k)) begin
                    data_o = data_i[k*flit_width_p +: flit_width_p];
                end
            end
            if ((state_r == LOCKED) || found) begin
                ready_and_o[cur] = ready_and_i;
            end
        end
    end

    assign locked_o = (state_r == LOCKED);
    assign hs       = v_o & ready_and_i;
    assign hdr_len  = data_o[cord_width_p +: len_width_p];

    always_comb begin
        state_n  = state_r;
        rr_ptr_n = rr_ptr_r;
        owner_n  = owner_r;
        remain_n = remain_r;
        case (state_r)
            IDLE: begin
                if (hs) begin
                    if (hdr_len != '0) begin
                        state_n  = LOCKED;
                        owner_n  = sel;
                        remain_n = hdr_len;
                    end else begin
                        rr_ptr_n = wrap_idx(sel, 1);
                    end
                end
            end
            LOCKED: begin
                if (hs) begin
                    remain_n = remain_r - 1'b1;
                    if (remain_r == len_width_p'(1)) begin
                        state_n  = IDLE;
                        rr_ptr_n = wrap_idx(owner_r, 1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            remain_r <= '0;
        end else begin
            state_r  <= state_n;
            rr_ptr_r <= rr_ptr_n;
            owner_r  <= owner_n;
            remain_r <= remain_n;
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(ready_and_o));
    a_ready_owner_only: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_r == LOCKED) |-> ((ready_and_o & ~(num_in_p'(1) << owner_r)) == '0));
`endif

endmodule

// File: tb/tb_bsg_wormhole_concentrator_arbiter.sv
// Directed bench for bsg_wormhole_concentrator_arbiter: reset, locking, round-robin order,
// bubbles/backpressure, zero-length packets, max-length packets and mid-packet reset.
module tb_bsg_wormhole_concentrator_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int LG = 2;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [N-1:0]      v_i;
    logic [N*W-1:0]    data_i;
    logic [N-1:0]      ready_and_o;
    logic              v_o;
    logic [W-1:0]      data_o;
    logic              ready_and_i;
    logic [LG-1:0]     grant_o;
    logic              locked_o;

    logic [W-1:0]      fl [N];
    int                tests = 0;
    int                fails = 0;
    int                cnt [N];
    int                sent;
    int                cycles;
    int                w;

    assign data_i = {fl[3], fl[2], fl[1], fl[0]};

    always #5 clk_i = ~clk_i;

    bsg_wormhole_concentrator_arbiter #(
        .num_in_p(N), .flit_width_p(W), .cord_width_p(5), .len_width_p(3)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o),
        .ready_and_i(ready_and_i), .grant_o(grant_o), .locked_o(locked_o)
    );

    // Flit = {input tag, sequence number, len, cord}
    function automatic logic [W-1:0] mk(input int k, input int seq, input int len);
        return {8'(k), 16'(seq), 3'(len), 5'(k + 1)};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [W-1:0] ed,
                             input logic [N-1:0] er, input logic [LG-1:0] eg, input logic el);
        chk({tag, ".v_o"}, W'(v_o), W'(ev));
        chk({tag, ".data_o"}, data_o, ed);
        chk({tag, ".ready_and_o"}, W'(ready_and_o), W'(er));
        chk({tag, ".grant_o"}, W'(grant_o), W'(eg));
        chk({tag, ".locked_o"}, W'(locked_o), W'(el));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset state, outputs quiet even with requests present
        reset_i     = 1'b1;
        ready_and_i = 1'b0;
        v_i         = '0;
        for (int k = 0; k < N; k++) fl[k] = mk(k, 0, 0);
        #2;
        check_out("rst_idle", 1'b0, fl[0], 4'b0000, 2'd0, 1'b0);
        v_i = 4'b1111;
        settle();
        check_out("rst_req", 1'b0, fl[0], 4'b0000, 2'd0, 1'b0);
        @(posedge clk_i);
        #3;
        reset_i = 1'b0;
        settle();
        check_out("rst_first", 1'b1, fl[0], 4'b0000, 2'd0, 1'b0);
        ready_and_i = 1'b1;
        settle();
        check_out("rst_first_rdy", 1'b1, fl[0], 4'b0001, 2'd0, 1'b0);
        v_i = 4'b0000;
        settle();
        check_out("idle_none", 1'b0, fl[0], 4'b0000, 2'd0, 1'b0);
        tick();

        // Single source: input 2, len 3
        fl[2] = mk(2, 0, 3);
        v_i   = 4'b0100;
        settle();
        check_out("b_hdr", 1'b1, fl[2], 4'b0100, 2'd2, 1'b0);
        tick();
        for (int j = 1; j <= 3; j++) begin
            fl[2] = mk(2, j, 0);
            settle();
            check_out("b_body", 1'b1, fl[2], 4'b0100, 2'd2, 1'b1);
            tick();
        end
        v_i         = 4'b1111;
        ready_and_i = 1'b0;
        for (int k = 0; k < N; k++) fl[k] = mk(k, 9, 0);
        settle();
        check_out("b_ptr3", 1'b1, fl[3], 4'b0000, 2'd3, 1'b0);

        reset_i = 1'b1;
        settle();
        tick();
        reset_i = 1'b0;

        // All inputs send len=1 packets back to back
        ready_and_i = 1'b1;
        v_i         = 4'b1111;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        for (int c = 0; c < 10; c++) begin
            w = (c / 2) % N;
            for (int k = 0; k < N; k++) fl[k] = mk(k, cnt[k], (cnt[k] % 2 == 0) ? 1 : 0);
            settle();
            check_out("c_rr", 1'b1, fl[w], 4'(1 << w), 2'(w), 1'(c % 2));
            cnt[w]++;
            tick();
        end

        // Input 1 locked with bubbles and backpressure while 0 and 3 request
        v_i   = 4'b1011;
        fl[0] = mk(0, 20, 0);
        fl[3] = mk(3, 20, 0);
        fl[1] = mk(1, 20, 2);
        settle();
        check_out("d_hdr", 1'b1, fl[1], 4'b0010, 2'd1, 1'b0);
        tick();
        v_i   = 4'b1001;
        fl[1] = mk(1, 21, 0);
        settle();
        check_out("d_bub1", 1'b0, fl[1], 4'b0010, 2'd1, 1'b1);
        tick();
        settle();
        check_out("d_bub2", 1'b0, fl[1], 4'b0010, 2'd1, 1'b1);
        tick();
        v_i         = 4'b1011;
        ready_and_i = 1'b0;
        settle();
        check_out("d_stall", 1'b1, fl[1], 4'b0000, 2'd1, 1'b1);
        tick();
        ready_and_i = 1'b1;
        settle();
        check_out("d_body1", 1'b1, fl[1], 4'b0010, 2'd1, 1'b1);
        tick();
        fl[1] = mk(1, 22, 0);
        settle();
        check_out("d_body2", 1'b1, fl[1], 4'b0010, 2'd1, 1'b1);
        tick();
        v_i = 4'b1001;
        settle();
        check_out("d_next3", 1'b1, fl[3], 4'b1000, 2'd3, 1'b0);
        tick();

        // Zero-length headers on inputs 0 and 1 together
        v_i   = 4'b0011;
        fl[0] = mk(0, 30, 0);
        fl[1] = mk(1, 30, 0);
        settle();
        check_out("e_in0", 1'b1, fl[0], 4'b0001, 2'd0, 1'b0);
        tick();
        v_i = 4'b0010;
        settle();
        check_out("e_in1", 1'b1, fl[1], 4'b0010, 2'd1, 1'b0);
        tick();
        v_i = 4'b0000;
        settle();
        check_out("e_idle", 1'b0, fl[0], 4'b0000, 2'd0, 1'b0);

        // Max-length packet on input 2 with random downstream ready
        v_i    = 4'b0100;
        sent   = 0;
        cycles = 0;
        while (sent < 8 && cycles < 200) begin
            fl[2]       = mk(2, 40 + sent, (sent == 0) ? 7 : 0);
            ready_and_i = 1'($urandom_range(0, 1));
            settle();
            check_out("f_flit", 1'b1, fl[2], ready_and_i ? 4'b0100 : 4'b0000, 2'd2, sent != 0);
            chk("f_remain", W'(dut.remain_r), W'((sent == 0) ? 0 : 8 - sent));
            if (ready_and_i) sent++;
            cycles++;
            tick();
        end
        chk("f_count", W'(sent), W'(8));
        v_i = 4'b0000;
        settle();
        check_out("f_done", 1'b0, fl[0], 4'b0000, 2'd0, 1'b0);
        chk("f_rem0", W'(dut.remain_r), W'(0));

        // Reset after four flits of a max-length packet
        v_i         = 4'b0100;
        ready_and_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            fl[2] = mk(2, 50 + j, (j == 0) ? 7 : 0);
            settle();
            check_out("g_flit", 1'b1, fl[2], 4'b0100, 2'd2, j != 0);
            tick();
        end
        settle();
        chk("g_locked", W'(locked_o), W'(1));
        #2;
        reset_i = 1'b1;
        #1;
        check_out("g_rst", 1'b0, fl[0], 4'b0000, 2'd0, 1'b0);
        chk("g_rst_remain", W'(dut.remain_r), W'(0));
        tick();
        reset_i     = 1'b0;
        v_i         = 4'b1111;
        ready_and_i = 1'b0;
        for (int k = 0; k < N; k++) fl[k] = mk(k, 60, 0);
        settle();
        check_out("g_ptr0", 1'b1, fl[0], 4'b0000, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
